nibble_serial_adder_ctrl: RTL and testbench

- Sequencer that performs WIDTH-bit add/subtract by reusing one 4-bit ripple-carry slice over multiple cycles, one nibble per clock, LSB nibble first.
- Holds operands, a carry register and the nibble counter, and presents a start/busy/done handshake to the requester.
- Sits between a requesting datapath and the shared 4-bit adder slice; trades latency for area against a full-width ripple adder.

---
 rtl/nibble_serial_adder_ctrl.sv | 96 +++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/subtract sequenced through one 4-bit slice, LSB nibble first
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             overflow
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, bx_q, bx_d, acc_q, acc_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [4:0]       slice;
    logic [WIDTH-1:0] res;

    // Next-state and datapath: accept in IDLE/DONE, one slice pass per RUN cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bx_d    = bx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        slice   = {1'b0, a_q[{cnt_q, 2'b00} +: 4]} + {1'b0, bx_q[{cnt_q, 2'b00} +: 4]} + {4'b0, carry_q};
        res     = acc_q;
        res[{cnt_q, 2'b00} +: 4] = slice[3:0];
        if (state_q != RUN && start) begin
            a_d     = A;
            bx_d    = op_sub ? ~B : B;
            carry_d = op_sub ? 1'b1 : Cin;
            cnt_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            acc_d   = res;
            carry_d = slice[4];
            if (cnt_q == CW'(NIB - 1)) begin
                state_d = DONE;
                sum_d   = res;
                cout_d  = slice[4];
                ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            bx_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign Sum      = sum_q;
    assign Cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: vector table, corner sequences and random ops against a full-width model
module tb_nibble_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, op_sub, Cin;
    logic [15:0] A, B;
    logic        busy, done, Cout, overflow;
    logic [15:0] Sum;
    int          tests = 0, fails = 0;
    logic [15:0] last_exp;

    typedef struct {
        logic        sub;
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] sum;
        logic        cout, ovf;
    } vec_t;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic sub, input logic [15:0] a, input logic [15:0] b, input logic cin);
        int sa, sb, sr;
        logic [16:0] u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        u  = sub ? 17'(a) - 17'(b) : 17'(a) + 17'(b) + 17'(cin);
        sr = sub ? sa - sb : sa + sb + int'(cin);
        return {(sr > 32767 || sr < -32768), sub ? ~u[16] : u[16], u[15:0]};
    endfunction

    task automatic wait_done();
        int n = 0, i = 0;
        while (!done && i < 20) begin
            if (busy) n++;
            chk("sum_hold", Sum, last_exp);
            @(negedge clk);
            i++;
        end
        chk("done_seen", done, 1);
        chk("busy_cycles", n, 4);
    endtask

    task automatic do_op(input logic sub, input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [17:0] r;
        r = model(sub, a, b, cin);
        op_sub = sub; A = a; B = b; Cin = cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; Cin = $urandom; op_sub = $urandom;
        wait_done();
        chk("sum", Sum, r[15:0]);
        chk("cout", Cout, r[16]);
        chk("ovf", overflow, r[17]);
        last_exp = r[15:0];
        @(negedge clk);
        chk("done_pulse_len", done, 0);
    endtask

    initial begin
        vec_t vt[5];
        logic [17:0] r1, r2;
        vt[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2] = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vt[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vt[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
        last_exp = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            op_sub = vt[i].sub; A = vt[i].a; B = vt[i].b; Cin = vt[i].cin; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done();
            chk("vec_sum", Sum, vt[i].sum);
            chk("vec_cout", Cout, vt[i].cout);
            chk("vec_ovf", overflow, vt[i].ovf);
            last_exp = vt[i].sum;
            @(negedge clk);
            chk("vec_done_len", done, 0);
        end
        r1 = model(1'b0, 16'h1111, 16'h2222, 1'b0);
        r2 = model(1'b1, 16'h0100, 16'h0ABC, 1'b0);
        op_sub = 1'b0; A = 16'h1111; B = 16'h2222; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        op_sub = 1'b1; A = 16'h0100; B = 16'h0ABC;
        wait_done();
        chk("ign_sum", Sum, r1[15:0]);
        chk("ign_cout", Cout, r1[16]);
        last_exp = r1[15:0];
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done", done, 0);
        wait_done();
        chk("b2b_sum", Sum, r2[15:0]);
        chk("b2b_cout", Cout, r2[16]);
        chk("b2b_ovf", overflow, r2[17]);
        last_exp = r2[15:0];
        @(negedge clk);
        op_sub = 1'b0; A = 16'h4444; B = 16'h1111; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", Sum, 0);
        chk("abort_cout", Cout, 0);
        chk("abort_ovf", overflow, 0);
        last_exp = '0;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_done", done, 0);
            @(negedge clk);
        end
        do_op(1'b0, 16'h4444, 16'h1111, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a, b;
            a = $urandom;
            b = (i % 8 == 0) ? ~a : 16'($urandom);
            do_op(1'($urandom), a, b, 1'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
